fp_normalize_round: RTL and testbench



---
 rtl/fp_normalize_round_pkg.sv | 25 ++
 rtl/fp_normalize_round_if.sv | 27 ++
 rtl/fp_normalize_round_lzc28.sv | 21 ++
 rtl/fp_normalize_round.sv | 195 +++++++++++++++++++
 tb/tb_fp_normalize_round.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/fp_normalize_round_pkg.sv
// Shared types and constants for the FP adder back end.
//   fp_state_e      : result class (OK/NAN/INF/NUL)
//   float_point_num : packed IEEE-754 single-precision word
//   QNAN, EXP_MAX, BIAS, MANT_EXT_W : format constants
package float_struct;

    typedef enum logic [1:0] {
        OK  = 2'b00,
        NAN = 2'b01,
        INF = 2'b10,
        NUL = 2'b11
    } fp_state_e;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } float_point_num;

    localparam logic [31:0] QNAN       = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX    = 8'hFF;
    localparam int          BIAS       = 127;
    localparam int          MANT_EXT_W = 28;

endpackage

// File: rtl/fp_normalize_round_if.sv
// Beat interface between the mantissa add/sub stage and the normalise/round stage.
//   in_vld/in_sign/in_exp/in_mant/in_state : unnormalised sum beat
//   result/state/res_vld                    : packed result, class and valid pulse
// master drives the sum beat; slave (the normaliser) drives the result.
interface fp_normalize_round_if;
    import float_struct::*;

    logic                  in_vld;
    logic                  in_sign;
    logic [7:0]            in_exp;
    logic [MANT_EXT_W-1:0] in_mant;
    fp_state_e             in_state;
    logic [31:0]           result;
    fp_state_e             state;
    logic                  res_vld;

    modport master (
        output in_vld, in_sign, in_exp, in_mant, in_state,
        input  result, state, res_vld
    );

    modport slave (
        input  in_vld, in_sign, in_exp, in_mant, in_state,
        output result, state, res_vld
    );

endinterface

// File: rtl/fp_normalize_round_lzc28.sv
// Combinational leading-zero counter for the 28-bit extended mantissa.
//   i_mant : extended mantissa
//   o_lz   : number of leading zeros, 0..28 (28 for an all-zero input)
module fp_lzc28
    import float_struct::*;
(
    input  logic [MANT_EXT_W-1:0] i_mant,
    output logic [4:0]            o_lz
);

    // Scanning upwards lets the most significant set bit overwrite the count last.
    always_comb begin
        o_lz = 5'd28;
        for (int i = 0; i < MANT_EXT_W; i++) begin
            if (i_mant[i]) begin
                o_lz = 5'(MANT_EXT_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_normalize_round.sv
// Final stage of the pipelined single-precision FP adder: normalise, round to
// nearest-even, classify overflow/underflow/specials and pack the IEEE word.
// Four register stages: S1 capture+LZC, S2 normalise, S3 round, output pack.
// A beat sampled at edge N is presented with res_vld after edge N+3.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : slave side of fp_normalize_round_if (sum beat in, result out)
module fp_normalize_round
    import float_struct::*;
#(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int FTZ    = 1
) (
    input  logic                clk,
    input  logic                rst,
    fp_normalize_round_if.slave bus
);

    generate
        if (FTZ != 1 || EXP_W != 8 || MANT_W != 23) begin : g_bad_cfg
            $error("fp_normalize_round: only EXP_W=8, MANT_W=23, FTZ=1 are implemented");
        end
    endgenerate

    // ---------------- S1: capture + leading-zero count ----------------
    logic [4:0]            w_lz;
    logic                  r_s1_vld;
    logic                  r_s1_sign;
    logic [7:0]            r_s1_exp;
    logic [MANT_EXT_W-1:0] r_s1_mant;
    fp_state_e             r_s1_state;
    logic [4:0]            r_s1_lz;

    fp_lzc28 u_lzc (
        .i_mant (bus.in_mant),
        .o_lz   (w_lz)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_mant  <= '0;
            r_s1_state <= OK;
            r_s1_lz    <= '0;
        end else begin
            r_s1_vld   <= bus.in_vld;
            r_s1_sign  <= bus.in_sign;
            r_s1_exp   <= bus.in_exp;
            r_s1_mant  <= bus.in_mant;
            r_s1_state <= bus.in_state;
            r_s1_lz    <= w_lz;
        end
    end

    // ---------------- S2: normalise ----------------
    // After normalisation the hidden bit sits at [26]; [2:0] are guard/round/sticky.
    logic [4:0]        w_s2_shamt;
    logic [26:0]       w_s2_mant;
    logic signed [9:0] w_s2_e;

    assign w_s2_shamt = r_s1_lz - 5'd1;

    always_comb begin
        w_s2_mant = '0;
        w_s2_e    = '0;
        if (r_s1_lz == 5'd0) begin
            // Carry set: shift right one, folding the dropped bit into sticky.
            w_s2_mant = {r_s1_mant[27:2], r_s1_mant[1] | r_s1_mant[0]};
            w_s2_e    = $signed({2'b00, r_s1_exp}) + 10'sd1;
        end else begin
            // Bit 27 is zero here, so the 27-bit shift loses nothing.
            w_s2_mant = r_s1_mant[26:0] << w_s2_shamt;
            w_s2_e    = $signed({2'b00, r_s1_exp}) - $signed({5'b00000, w_s2_shamt});
        end
    end

    logic              r_s2_vld;
    logic              r_s2_sign;
    fp_state_e         r_s2_state;
    logic              r_s2_zero;
    logic signed [9:0] r_s2_e;
    logic [26:0]       r_s2_mant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_vld   <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_state <= OK;
            r_s2_zero  <= 1'b0;
            r_s2_e     <= '0;
            r_s2_mant  <= '0;
        end else begin
            r_s2_vld   <= r_s1_vld;
            r_s2_sign  <= r_s1_sign;
            r_s2_state <= r_s1_state;
            r_s2_zero  <= (r_s1_lz == 5'd28);
            r_s2_e     <= w_s2_e;
            r_s2_mant  <= w_s2_mant;
        end
    end

    // ---------------- S3: round to nearest-even ----------------
    logic              w_round_up;
    logic [24:0]       w_sum;
    logic [22:0]       w_s3_frac;
    logic signed [9:0] w_s3_e;

    assign w_round_up = r_s2_mant[2] & (r_s2_mant[1] | r_s2_mant[0] | r_s2_mant[3]);
    assign w_sum      = {1'b0, r_s2_mant[26:3]} + {24'b0, w_round_up};
    // A carry out of the rounding add means the mantissa became 10.000...; renormalise.
    assign w_s3_frac  = w_sum[24] ? w_sum[23:1] : w_sum[22:0];
    assign w_s3_e     = r_s2_e + $signed({9'b0, w_sum[24]});

    logic              r_s3_vld;
    logic              r_s3_sign;
    fp_state_e         r_s3_state;
    logic              r_s3_zero;
    logic signed [9:0] r_s3_e;
    logic [22:0]       r_s3_frac;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_vld   <= 1'b0;
            r_s3_sign  <= 1'b0;
            r_s3_state <= OK;
            r_s3_zero  <= 1'b0;
            r_s3_e     <= '0;
            r_s3_frac  <= '0;
        end else begin
            r_s3_vld   <= r_s2_vld;
            r_s3_sign  <= r_s2_sign;
            r_s3_state <= r_s2_state;
            r_s3_zero  <= r_s2_zero;
            r_s3_e     <= w_s3_e;
            r_s3_frac  <= w_s3_frac;
        end
    end

    // ---------------- Output: classify + pack ----------------
    float_point_num w_pack;
    fp_state_e      w_out_state;

    always_comb begin
        w_pack      = '0;
        w_out_state = OK;
        if (r_s3_state == NAN) begin
            w_pack      = QNAN;
            w_out_state = NAN;
        end else if (r_s3_state == INF) begin
            w_pack      = '{sign: r_s3_sign, exp: EXP_MAX, frac: 23'h0};
            w_out_state = INF;
        end else if (r_s3_state == NUL) begin
            w_pack.sign = r_s3_sign;
            w_out_state = NUL;
        end else if (r_s3_zero) begin
            // Exact cancellation is always +0.
            w_out_state = NUL;
        end else if (r_s3_e >= 10'sd255) begin
            w_pack      = '{sign: r_s3_sign, exp: EXP_MAX, frac: 23'h0};
            w_out_state = INF;
        end else if (r_s3_e <= 10'sd0) begin
            w_pack.sign = r_s3_sign;
            w_out_state = NUL;
        end else begin
            w_pack      = '{sign: r_s3_sign, exp: r_s3_e[7:0], frac: r_s3_frac};
            w_out_state = OK;
        end
    end

    logic [31:0] r_result;
    fp_state_e   r_state;
    logic        r_res_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result  <= '0;
            r_state   <= OK;
            r_res_vld <= 1'b0;
        end else begin
            r_res_vld <= r_s3_vld;
            if (r_s3_vld) begin
                r_result <= w_pack;
                r_state  <= w_out_state;
            end
        end
    end

    assign bus.result  = r_result;
    assign bus.state   = r_state;
    assign bus.res_vld = r_res_vld;

endmodule

// File: tb/tb_fp_normalize_round.sv
module tb_fp_normalize_round;
    import float_struct::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_normalize_round_if bus ();

    fp_normalize_round dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic [1:0]  st;
        int          issue;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Advance one edge, then look at the outputs 1 time unit later.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.res_vld === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_res_vld", {31'b0, bus.res_vld}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", bus.result, e.res);
                check("state", {30'b0, bus.state}, {30'b0, e.st});
                check("latency", cyc - e.issue, 32'd3);
            end
        end
    endtask

    task automatic drive(input logic s, input logic [7:0] ex, input logic [27:0] m,
                         input fp_state_e st, input logic [31:0] xr, input logic [1:0] xs,
                         input bit push = 1'b1);
        exp_t e;
        bus.in_vld   = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = ex;
        bus.in_mant  = m;
        bus.in_state = st;
        if (push) begin
            e.res   = xr;
            e.st    = xs;
            e.issue = cyc + 1;
            sb.push_back(e);
        end
        tick();
    endtask

    task automatic idle(input int n);
        bus.in_vld = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_vld   = 1'b0;
        bus.in_sign  = 1'b0;
        bus.in_exp   = '0;
        bus.in_mant  = '0;
        bus.in_state = OK;
        repeat (3) tick();
        check("rst_result", bus.result, 32'h0);
        check("rst_state", {30'b0, bus.state}, 32'd0);
        check("rst_res_vld", {31'b0, bus.res_vld}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Carry normalise, then hold while idle
        drive(1'b0, 8'd127, 28'h8000000, OK, 32'h40000000, 2'b00);
        idle(6);
        check("hold_result", bus.result, 32'h40000000);
        check("hold_res_vld", {31'b0, bus.res_vld}, 32'd0);

        // Tie-to-even and rounding carry
        drive(1'b0, 8'd127, 28'h4000004, OK, 32'h3F800000, 2'b00);
        idle(4);
        drive(1'b0, 8'd127, 28'h400000C, OK, 32'h3F800002, 2'b00);
        idle(4);
        drive(1'b0, 8'd127, 28'h7FFFFFC, OK, 32'h40000000, 2'b00);
        idle(4);

        // Sticky from the right shift tips a round-up; exact tie after shift stays even
        drive(1'b0, 8'd127, 28'h8000009, OK, 32'h40000001, 2'b00);
        drive(1'b0, 8'd127, 28'h8000008, OK, 32'h40000000, 2'b00);
        idle(4);

        // Left normalise, negative value, underflow flush
        drive(1'b0, 8'd127, 28'h1000000, OK, 32'h3E800000, 2'b00);
        drive(1'b1, 8'd130, 28'h6000000, OK, 32'hC1400000, 2'b00);
        drive(1'b1, 8'd1,   28'h1000000, OK, 32'h80000000, 2'b11);
        idle(4);

        // Cancellation and overflow
        drive(1'b1, 8'd90,  28'h0,       OK, 32'h00000000, 2'b11);
        drive(1'b0, 8'd254, 28'h8000000, OK, 32'h7F800000, 2'b10);
        drive(1'b1, 8'd254, 28'hFFFFFFF, OK, 32'hFF800000, 2'b10);
        idle(4);

        // Specials streamed back to back
        drive(1'b0, 8'd127, 28'h4000000, OK,  32'h3F800000, 2'b00);
        drive(1'b0, 8'd3,   28'h1234567, NAN, 32'h7FC00000, 2'b01);
        drive(1'b1, 8'd200, 28'h4000000, INF, 32'hFF800000, 2'b10);
        drive(1'b0, 8'd128, 28'h4000000, OK,  32'h40000000, 2'b00);
        drive(1'b1, 8'd100, 28'h4000000, NUL, 32'h80000000, 2'b11);
        idle(6);

        // Reset mid-flight: two beats in the pipe are discarded
        drive(1'b0, 8'd127, 28'h4000000, OK, 32'h0, 2'b00, 1'b0);
        drive(1'b0, 8'd127, 28'h8000000, OK, 32'h0, 2'b00, 1'b0);
        bus.in_vld = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_flight_no_vld", {31'b0, bus.res_vld}, 32'd0);
        end
        check("rst_flight_result", bus.result, 32'h0);
        check("rst_flight_state", {30'b0, bus.state}, 32'd0);

        drive(1'b0, 8'd127, 28'h1000000, OK, 32'h3E800000, 2'b00);
        idle(8);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
